// File: rtl/bcd_counter_2d_pkg.sv
// Shared types and helpers for the two-digit BCD counter.
// Imported by the prescaler, the handshake interface and the top level.
package bcd_counter_2d_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    // Binary value of a tens/ones pair; 8 bits holds 15*10+15.
    function automatic logic [7:0] bcd_val(bcd_t t, bcd_t o);
        return 8'(t) * 8'd10 + 8'(o);
    endfunction

endpackage

// File: rtl/bcd_counter_2d_if.sv
// Control and digit bundle of the BCD counter.
// master drives controls, slave is the counter.
interface bcd_counter_2d_if;
    import bcd_counter_2d_pkg::*;

    logic en;
    logic up;
    logic clr;
    logic load;
    bcd_t load_tens;
    bcd_t load_ones;
    bcd_t digit_tens;
    bcd_t digit_ones;
    logic tick;
    logic wrap;

    modport master (
        output en, up, clr, load,
        output load_tens, load_ones,
        input  digit_tens, digit_ones,
        input  tick, wrap
    );

    modport slave (
        input  en, up, clr, load,
        input  load_tens, load_ones,
        output digit_tens, digit_ones,
        output tick, wrap
    );

endinterface

// File: rtl/bcd_counter_2d_tick_gen.sv
// Prescaler: counts 0..CLK_DIV-1 while enabled.
// strobe is high in the cycle that returns the count to 0.
module tick_gen #(
    parameter int CLK_DIV = 12_000_000,
    parameter int DIV_W   = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_clr,
    output logic strobe
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt;

    // A clear wins over the terminal count, so no step is issued.
    assign strobe = en && !sync_clr && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (sync_clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST)
                cnt <= '0;
            else
                cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/bcd_counter_2d.sv
// Two-digit BCD up/down counter with built-in tick prescaler.
// tens feeds decoder data1, ones feeds decoder data2.
module bcd_counter_2d
    import bcd_counter_2d_pkg::*;
#(
    parameter int CLK_DIV = 12_000_000,
    parameter int MOD     = 100,
    parameter int DIV_W   = 24
) (
    input logic          clk,
    input logic          rst,
    bcd_counter_2d_if.slave bus
);

    localparam bcd_t MOD_TENS = bcd_t'((MOD - 1) / 10);
    localparam bcd_t MOD_ONES = bcd_t'((MOD - 1) % 10);
    localparam logic [7:0] MOD_V = 8'(MOD);

    logic step;
    logic sync_clr;
    bcd_t tens_q, ones_q;
    bcd_t tens_d, ones_d;
    logic tick_q, wrap_q;
    logic wrap_d;
    logic at_max, at_zero;
    logic load_bad;

    assign sync_clr = bus.clr | bus.load;

    tick_gen #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W)
    ) u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (bus.en),
        .sync_clr (sync_clr),
        .strobe   (step)
    );

    // Full-pair compare so moduli like 45 wrap correctly.
    assign at_max  = (tens_q == MOD_TENS) && (ones_q == MOD_ONES);
    assign at_zero = (tens_q == '0) && (ones_q == '0);

    assign load_bad = (bus.load_tens > 4'd9)
                   || (bus.load_ones > 4'd9)
                   || (bcd_val(bus.load_tens, bus.load_ones) >= MOD_V);

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        wrap_d = 1'b0;
        if (bus.clr) begin
            tens_d = '0;
            ones_d = '0;
        end else if (bus.load) begin
            tens_d = load_bad ? MOD_TENS : bus.load_tens;
            ones_d = load_bad ? MOD_ONES : bus.load_ones;
        end else if (step) begin
            if (bus.up) begin
                if (at_max) begin
                    tens_d = '0;
                    ones_d = '0;
                    wrap_d = 1'b1;
                end else if (ones_q == 4'd9) begin
                    ones_d = '0;
                    tens_d = tens_q + 4'd1;
                end else begin
                    ones_d = ones_q + 4'd1;
                end
            end else begin
                if (at_zero) begin
                    tens_d = MOD_TENS;
                    ones_d = MOD_ONES;
                    wrap_d = 1'b1;
                end else if (ones_q == 4'd0) begin
                    ones_d = 4'd9;
                    tens_d = tens_q - 4'd1;
                end else begin
                    ones_d = ones_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens_q <= '0;
            ones_q <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
            tick_q <= step;
            wrap_q <= wrap_d;
        end
    end

    assign bus.digit_tens = tens_q;
    assign bus.digit_ones = ones_q;
    assign bus.tick       = tick_q;
    assign bus.wrap       = wrap_q;

endmodule

// File: tb/tb_bcd_counter_2d.sv
// Bench for bcd_counter_2d: two instances (MOD=100, MOD=60) on shared
// stimulus, checked against an integer reference model.
module tb_bcd_counter_2d;

    localparam int CDIV = 4;
    localparam int MODS [2] = '{100, 60};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic up = 1'b1;
    logic clr = 1'b0;
    logic load = 1'b0;
    logic [3:0] lt = '0;
    logic [3:0] lo = '0;

    int total = 0;
    int passed = 0;

    int  mval [2];
    int  mpc [2];
    bit  mtick [2];
    bit  mwrap [2];

    bcd_counter_2d_if ifa ();
    bcd_counter_2d_if ifb ();

    assign ifa.en = en;
    assign ifa.up = up;
    assign ifa.clr = clr;
    assign ifa.load = load;
    assign ifa.load_tens = lt;
    assign ifa.load_ones = lo;
    assign ifb.en = en;
    assign ifb.up = up;
    assign ifb.clr = clr;
    assign ifb.load = load;
    assign ifb.load_tens = lt;
    assign ifb.load_ones = lo;

    bcd_counter_2d #(.CLK_DIV(CDIV), .MOD(100), .DIV_W(3)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    bcd_counter_2d #(.CLK_DIV(CDIV), .MOD(60), .DIV_W(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t;
        int o;
        int exp_a;
        int exp_b;
    } load_vec_t;

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    endtask

    function automatic int val_of(int i);
        if (i == 0)
            return int'(ifa.digit_tens) * 10 + int'(ifa.digit_ones);
        return int'(ifb.digit_tens) * 10 + int'(ifb.digit_ones);
    endfunction

    function automatic int tick_of(int i);
        return (i == 0) ? int'(ifa.tick) : int'(ifb.tick);
    endfunction

    function automatic int wrap_of(int i);
        return (i == 0) ? int'(ifa.wrap) : int'(ifb.wrap);
    endfunction

    function automatic bit bcd_ok(int i);
        if (i == 0)
            return ifa.digit_tens <= 9 && ifa.digit_ones <= 9;
        return ifb.digit_tens <= 9 && ifb.digit_ones <= 9;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mval[i] = 0;
            mpc[i] = 0;
            mtick[i] = 0;
            mwrap[i] = 0;
        end
    endtask

    task automatic model_step(int i);
        int m = MODS[i];
        mtick[i] = 0;
        mwrap[i] = 0;
        if (clr) begin
            mval[i] = 0;
            mpc[i] = 0;
        end else if (load) begin
            mpc[i] = 0;
            if (lt > 9 || lo > 9 || lt * 10 + lo >= m)
                mval[i] = m - 1;
            else
                mval[i] = lt * 10 + lo;
        end else if (en) begin
            if (mpc[i] == CDIV - 1) begin
                mpc[i] = 0;
                mtick[i] = 1;
                if (up) begin
                    mwrap[i] = (mval[i] == m - 1);
                    mval[i] = (mval[i] + 1) % m;
                end else begin
                    mwrap[i] = (mval[i] == 0);
                    mval[i] = (mval[i] + m - 1) % m;
                end
            end else begin
                mpc[i]++;
            end
        end
    endtask

    // One clock: advance model, then compare just after the edge.
    task automatic cycle();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("value%0d", i), val_of(i), mval[i]);
            chk($sformatf("tick%0d", i), tick_of(i), int'(mtick[i]));
            chk($sformatf("wrap%0d", i), wrap_of(i), int'(mwrap[i]));
            chk($sformatf("bcd%0d", i), int'(bcd_ok(i)), 1);
        end
    endtask

    task automatic do_load(int t, int o);
        lt = 4'(t);
        lo = 4'(o);
        load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++)
            cycle();
    endtask

    load_vec_t vecs [8];
    int edges;
    int wa, wb;

    initial begin
        vecs[0] = '{7, 3, 73, 59};
        vecs[1] = '{2, 12, 99, 59};
        vecs[2] = '{4, 5, 45, 45};
        vecs[3] = '{9, 8, 98, 59};
        vecs[4] = '{15, 15, 99, 59};
        vecs[5] = '{5, 9, 59, 59};
        vecs[6] = '{6, 0, 60, 59};
        vecs[7] = '{0, 0, 0, 0};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_val%0d", i), val_of(i), 0);
            chk($sformatf("rst_tick%0d", i), tick_of(i), 0);
            chk($sformatf("rst_wrap%0d", i), wrap_of(i), 0);
        end
        rst = 1'b0;

        // Load / clamp table
        en = 1'b0;
        foreach (vecs[k]) begin
            do_load(vecs[k].t, vecs[k].o);
            chk($sformatf("load_a_%0d", k), val_of(0), vecs[k].exp_a);
            chk($sformatf("load_b_%0d", k), val_of(1), vecs[k].exp_b);
        end

        // Up wrap and tens carry
        up = 1'b1;
        en = 1'b1;
        do_load(9, 8);
        run(CDIV);
        chk("upwrap_99", val_of(0), 99);
        run(CDIV);
        chk("upwrap_00", val_of(0), 0);
        chk("upwrap_pulse", wrap_of(0), 1);
        chk("upwrap_tick", tick_of(0), 1);
        run(1);
        chk("upwrap_one", wrap_of(0), 0);
        do_load(1, 9);
        run(CDIV);
        chk("carry_20", val_of(0), 20);

        // Down wrap at MOD=60
        up = 1'b0;
        do_load(0, 1);
        run(CDIV);
        chk("down_00", val_of(1), 0);
        run(CDIV);
        chk("down_59", val_of(1), 59);
        chk("down_wrap", wrap_of(1), 1);
        run(CDIV);
        chk("down_58", val_of(1), 58);
        chk("down_nowrap", wrap_of(1), 0);

        // clr + load on a terminal-count cycle
        up = 1'b1;
        do_load(4, 2);
        run(CDIV - 1);
        clr = 1'b1;
        load = 1'b1;
        lt = 4'd5;
        lo = 4'd5;
        cycle();
        clr = 1'b0;
        load = 1'b0;
        chk("prio_val", val_of(0), 0);
        chk("prio_wrap", wrap_of(0), 0);
        chk("prio_val_b", val_of(1), 0);

        // Enable freeze and resume from held prescaler
        do_load(2, 0);
        run(2);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("freeze_val", val_of(0), 20);
            chk("freeze_tick", tick_of(0), 0);
        end
        en = 1'b1;
        run(1);
        chk("resume_wait", val_of(0), 20);
        run(1);
        chk("resume_val", val_of(0), 21);
        chk("resume_tick", tick_of(0), 1);

        // Asynchronous reset mid-count
        do_load(3, 6);
        run(CDIV);
        chk("pre_rst_37", val_of(0), 37);
        #2 rst = 1'b1;
        #1;
        chk("async_val", val_of(0), 0);
        chk("async_val_b", val_of(1), 0);
        chk("async_tick", tick_of(0), 0);
        chk("async_wrap", wrap_of(0), 0);
        #2 rst = 1'b0;
        model_reset();
        edges = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            edges++;
            if (val_of(0) != 0)
                break;
        end
        chk("first_step_edges", edges, CDIV);
        chk("first_step_val", val_of(0), 1);

        // Randomized stimulus against the model
        for (int k = 0; k < 600; k++) begin
            en = ($urandom_range(0, 9) != 0);
            up = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 59) == 0);
            load = ($urandom_range(0, 29) == 0);
            lt = 4'($urandom_range(0, 15));
            lo = 4'($urandom_range(0, 15));
            cycle();
        end
        clr = 1'b0;
        load = 1'b0;

        // Long run: 250 ticks from 00
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        en = 1'b1;
        up = 1'b1;
        wa = 0;
        wb = 0;
        for (int k = 0; k < 250 * CDIV; k++) begin
            cycle();
            wa += wrap_of(0);
            wb += wrap_of(1);
        end
        chk("long_val_a", val_of(0), 50);
        chk("long_wraps_a", wa, 2);
        chk("long_val_b", val_of(1), 10);
        chk("long_wraps_b", wb, 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
